// File: rtl/ctrl_unit_pkg.sv
// rtl/ctrl_unit_pkg.sv - ctrl_unit shared definitions: state encodings, opcodes, select constants
package ctrl_defs;

    // FSM state encodings
    localparam logic [4:0] S_IF       = 5'd0;
    localparam logic [4:0] S_ID       = 5'd1;
    localparam logic [4:0] S_EX_R     = 5'd2;
    localparam logic [4:0] S_WB_R     = 5'd3;
    localparam logic [4:0] S_EX_I     = 5'd4;
    localparam logic [4:0] S_WB_I     = 5'd5;
    localparam logic [4:0] S_EX_LUI   = 5'd6;
    localparam logic [4:0] S_MEM_ADDR = 5'd7;
    localparam logic [4:0] S_MEM_RD   = 5'd8;
    localparam logic [4:0] S_WB_LW    = 5'd9;
    localparam logic [4:0] S_MEM_WR   = 5'd10;
    localparam logic [4:0] S_EX_BR    = 5'd11;
    localparam logic [4:0] S_EX_J     = 5'd12;
    localparam logic [4:0] S_EX_JAL   = 5'd13;
    localparam logic [4:0] S_EX_JR    = 5'd14;

    // Opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (Inst[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    // Datapath mux selects
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;

    localparam logic [1:0] M2R_ALU     = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_LUI     = 2'b10;
    localparam logic [1:0] M2R_PC      = 2'b11;

    localparam logic [1:0] SRCA_RS     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BR     = 2'b11;

    localparam logic [2:0] PCSRC_RES    = 3'b000;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_JR     = 3'b011;
    localparam logic [2:0] PCSRC_HOLD   = 3'b100;

    // What the current state asks of the ALU decoder
    typedef enum logic [1:0] {
        ACLS_ADD   = 2'b00,
        ACLS_SUB   = 2'b01,
        ACLS_RTYPE = 2'b10,
        ACLS_ITYPE = 2'b11
    } alu_class_e;

    // Successor of ID; S_IF marks an undefined opcode.
    function automatic logic [4:0] id_next_state(input logic [5:0] opcode,
                                                 input logic [5:0] funct);
        logic [4:0] nxt;
        case (opcode)
            OP_RTYPE:                nxt = (funct == FN_JR) ? S_EX_JR : S_EX_R;
            OP_LW, OP_SW:            nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE:          nxt = S_EX_BR;
            OP_J:                    nxt = S_EX_J;
            OP_JAL:                  nxt = S_EX_JAL;
            OP_LUI:                  nxt = S_EX_LUI;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI:         nxt = S_EX_I;
            default:                 nxt = S_IF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - ctrl_unit to data_path control bundle
// master: controller side (drives controls, receives instruction/flags/ready)
// slave:  datapath/memory side
interface ctrl_unit_if #(
    parameter int STATE_W = 5
);
    logic [31:0]        Inst_in;
    logic               zero;
    logic               overflow;
    logic               MIO_ready;
    logic               IorD;
    logic               IRWrite;
    logic [1:0]         RegDst;
    logic               RegWrite;
    logic [1:0]         MemtoReg;
    logic               data2Mem;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         PCSource;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               Beq;
    logic               Signext;
    logic [3:0]         ALU_operation;
    logic               MemRead;
    logic               MemWrite;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  Inst_in, zero, overflow, MIO_ready,
        output IorD, IRWrite, RegDst, RegWrite, MemtoReg, data2Mem,
               ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Beq,
               Signext, ALU_operation, MemRead, MemWrite, illegal, state
    );

    modport slave (
        output Inst_in, zero, overflow, MIO_ready,
        input  IorD, IRWrite, RegDst, RegWrite, MemtoReg, data2Mem,
               ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Beq,
               Signext, ALU_operation, MemRead, MemWrite, illegal, state
    );
endinterface

// File: rtl/ctrl_unit_alu_ctrl.sv
// rtl/ctrl_unit_alu_ctrl.sv - ALU operation decoder
// cls_i: state class, opcode_i/funct_i: instruction fields
// alu_op_o: ALU code, illegal_o: undefined funct/opcode, add_type_o: op can overflow
module alu_ctrl
    import ctrl_defs::*;
(
    input  alu_class_e  cls_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output logic [3:0]  alu_op_o,
    output logic        illegal_o,
    output logic        add_type_o
);

    always_comb begin
        alu_op_o   = ALU_ADD;
        illegal_o  = 1'b0;
        add_type_o = 1'b0;
        case (cls_i)
            ACLS_ADD: alu_op_o = ALU_ADD;
            ACLS_SUB: alu_op_o = ALU_SUB;
            ACLS_RTYPE: begin
                case (funct_i)
                    FN_ADD: begin alu_op_o = ALU_ADD; add_type_o = 1'b1; end
                    FN_SUB: begin alu_op_o = ALU_SUB; add_type_o = 1'b1; end
                    FN_AND: alu_op_o = ALU_AND;
                    FN_OR:  alu_op_o = ALU_OR;
                    FN_XOR: alu_op_o = ALU_XOR;
                    FN_NOR: alu_op_o = ALU_NOR;
                    FN_SLT: alu_op_o = ALU_SLT;
                    FN_SLL: alu_op_o = ALU_SLL;
                    FN_SRL: alu_op_o = ALU_SRL;
                    default: illegal_o = 1'b1;
                endcase
            end
            ACLS_ITYPE: begin
                case (opcode_i)
                    OP_ADDI: begin alu_op_o = ALU_ADD; add_type_o = 1'b1; end
                    OP_SLTI: alu_op_o = ALU_SLT;
                    OP_ANDI: alu_op_o = ALU_AND;
                    OP_ORI:  alu_op_o = ALU_OR;
                    OP_XORI: alu_op_o = ALU_XOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - multicycle Moore controller for the MIPS multicycle datapath
// clk: rising-edge clock, reset: async active-high
// bus: ctrl_unit_if master (instruction/flags/ready in, all datapath controls out)
module ctrl_unit
    import ctrl_defs::*;
#(
    parameter int STATE_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    ctrl_unit_if.master bus
);

    logic [4:0] state_q, state_d;
    logic       ovf_q, ovf_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = bus.Inst_in[31:26];
    assign funct  = bus.Inst_in[5:0];

    // rt is only meaningful to the datapath (jr assumes $0); zero is folded in
    // by the datapath using PCWriteCond/Beq.
    logic unused_inputs;
    assign unused_inputs = ^{bus.Inst_in[25:6], bus.zero};

    alu_class_e alu_cls;
    logic [3:0] alu_op;
    logic       alu_illegal;
    logic       alu_add_type;

    alu_ctrl u_alu_ctrl (
        .cls_i      (alu_cls),
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_op_o   (alu_op),
        .illegal_o  (alu_illegal),
        .add_type_o (alu_add_type)
    );

    logic       iord, irwrite, regwrite, pcwrite, pcwritecond, beq, signext;
    logic       memread, memwrite, illegal;
    logic [1:0] regdst, memtoreg, srca, srcb;
    logic [2:0] pcsource;
    logic [4:0] id_nxt;

    always_comb begin
        state_d     = state_q;
        ovf_d       = ovf_q;
        alu_cls     = ACLS_ADD;
        iord        = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        beq         = 1'b0;
        signext     = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        illegal     = 1'b0;
        regdst      = REGDST_RT;
        memtoreg    = M2R_ALU;
        srca        = SRCA_RS;
        srcb        = SRCB_RT;
        pcsource    = PCSRC_HOLD;
        id_nxt      = id_next_state(opcode, funct);

        case (state_q)
            S_IF: begin
                iord     = 1'b1;
                memread  = 1'b1;
                srca     = SRCA_PC;
                srcb     = SRCB_FOUR;
                pcsource = PCSRC_RES;
                // IR and PC+4 commit only on the cycle the fetch completes
                irwrite  = bus.MIO_ready;
                pcwrite  = bus.MIO_ready;
                ovf_d    = 1'b0;
                if (bus.MIO_ready) state_d = S_ID;
            end
            S_ID: begin
                // Precompute the branch target into ALU_Out
                srca    = SRCA_PC;
                srcb    = SRCB_BR;
                state_d = id_nxt;
                illegal = (id_nxt == S_IF);
            end
            S_EX_R: begin
                alu_cls = ACLS_RTYPE;
                if (alu_illegal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_WB_R;
                    if (alu_add_type && bus.overflow) ovf_d = 1'b1;
                end
            end
            S_WB_R: begin
                regdst   = REGDST_RD;
                regwrite = !ovf_q;
                state_d  = S_IF;
            end
            S_EX_I: begin
                alu_cls = ACLS_ITYPE;
                srcb    = SRCB_IMM;
                signext = (opcode == OP_ADDI) || (opcode == OP_SLTI);
                if (alu_illegal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_WB_I;
                    if (alu_add_type && bus.overflow) ovf_d = 1'b1;
                end
            end
            S_WB_I: begin
                regwrite = !ovf_q;
                state_d  = S_IF;
            end
            S_EX_LUI: begin
                memtoreg = M2R_LUI;
                regwrite = 1'b1;
                state_d  = S_IF;
            end
            S_MEM_ADDR: begin
                srcb    = SRCB_IMM;
                signext = 1'b1;
                state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                memread = 1'b1;
                if (bus.MIO_ready) state_d = S_WB_LW;
            end
            S_WB_LW: begin
                memtoreg = M2R_MDR;
                regwrite = 1'b1;
                state_d  = S_IF;
            end
            S_MEM_WR: begin
                memwrite = 1'b1;
                if (bus.MIO_ready) state_d = S_IF;
            end
            S_EX_BR: begin
                alu_cls     = ACLS_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                beq         = (opcode == OP_BEQ);
                state_d     = S_IF;
            end
            S_EX_J: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                state_d  = S_IF;
            end
            S_EX_JAL: begin
                // PC already holds PC+4 from IF, so $31 gets the return address
                regdst   = REGDST_RA;
                memtoreg = M2R_PC;
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                state_d  = S_IF;
            end
            S_EX_JR: begin
                // rs + $0 through the ALU; PCSource 011 takes the live result
                pcwrite  = 1'b1;
                pcsource = PCSRC_JR;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.IorD          = iord;
    assign bus.IRWrite       = irwrite;
    assign bus.RegDst        = regdst;
    assign bus.RegWrite      = regwrite;
    assign bus.MemtoReg      = memtoreg;
    assign bus.data2Mem      = 1'b0;
    assign bus.ALUSrcA       = srca;
    assign bus.ALUSrcB       = srcb;
    assign bus.PCSource      = pcsource;
    assign bus.PCWrite       = pcwrite;
    assign bus.PCWriteCond   = pcwritecond;
    assign bus.Beq           = beq;
    assign bus.Signext       = signext;
    assign bus.ALU_operation = alu_op;
    assign bus.MemRead       = memread;
    assign bus.MemWrite      = memwrite;
    assign bus.illegal       = illegal;
    assign bus.state         = STATE_W'(state_q);

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - scoreboard testbench for ctrl_unit
module tb_ctrl_unit;

    localparam int SEL_STATE = 0,  SEL_IORD = 1,  SEL_IRW  = 2,  SEL_REGDST = 3;
    localparam int SEL_REGW  = 4,  SEL_M2R  = 5,  SEL_SRCA = 6,  SEL_SRCB   = 7;
    localparam int SEL_PCSRC = 8,  SEL_PCW  = 9,  SEL_PCWC = 10, SEL_BEQ    = 11;
    localparam int SEL_SEXT  = 12, SEL_ALU  = 13, SEL_MRD  = 14, SEL_MWR    = 15;
    localparam int SEL_ILL   = 16, SEL_D2M  = 17;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    exp_t  sb_q[$];
    string tag_q[$];

    ctrl_unit_if #(.STATE_W(5)) bus ();

    ctrl_unit #(.STATE_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_STATE:  return 32'(bus.state);
            SEL_IORD:   return 32'(bus.IorD);
            SEL_IRW:    return 32'(bus.IRWrite);
            SEL_REGDST: return 32'(bus.RegDst);
            SEL_REGW:   return 32'(bus.RegWrite);
            SEL_M2R:    return 32'(bus.MemtoReg);
            SEL_SRCA:   return 32'(bus.ALUSrcA);
            SEL_SRCB:   return 32'(bus.ALUSrcB);
            SEL_PCSRC:  return 32'(bus.PCSource);
            SEL_PCW:    return 32'(bus.PCWrite);
            SEL_PCWC:   return 32'(bus.PCWriteCond);
            SEL_BEQ:    return 32'(bus.Beq);
            SEL_SEXT:   return 32'(bus.Signext);
            SEL_ALU:    return 32'(bus.ALU_operation);
            SEL_MRD:    return 32'(bus.MemRead);
            SEL_MWR:    return 32'(bus.MemWrite);
            SEL_ILL:    return 32'(bus.illegal);
            SEL_D2M:    return 32'(bus.data2Mem);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_sig(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, observe(e.sel), e.exp);
        end
    endtask

    // One clock: apply inputs, compare queued expectations at the falling edge
    task automatic cyc(input logic rdy, input logic ovf);
        bus.MIO_ready = rdy;
        bus.overflow  = ovf;
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] inst);
        bus.Inst_in = inst;
        exp_sig({tag, "_if_state"}, SEL_STATE, 0);
        exp_sig({tag, "_if_irw"},   SEL_IRW,   1);
        exp_sig({tag, "_if_pcw"},   SEL_PCW,   1);
        cyc(1'b1, 1'b0);
        exp_sig({tag, "_id_state"}, SEL_STATE, 1);
        exp_sig({tag, "_id_srcb"},  SEL_SRCB,  3);
        exp_sig({tag, "_id_ill"},   SEL_ILL,   0);
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.Inst_in   = 32'h0;
        bus.zero      = 1'b0;
        bus.overflow  = 1'b0;
        bus.MIO_ready = 1'b0;

        // Reset: outputs are the IF decode, ready low so no IR/PC write
        #2;
        exp_sig("rst_state", SEL_STATE, 0);
        exp_sig("rst_iord",  SEL_IORD,  1);
        exp_sig("rst_mrd",   SEL_MRD,   1);
        exp_sig("rst_srca",  SEL_SRCA,  1);
        exp_sig("rst_srcb",  SEL_SRCB,  1);
        exp_sig("rst_alu",   SEL_ALU,   4'b0010);
        exp_sig("rst_pcsrc", SEL_PCSRC, 0);
        exp_sig("rst_irw",   SEL_IRW,   0);
        exp_sig("rst_d2m",   SEL_D2M,   0);
        drain();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // IF with ready low holds
        exp_sig("ifwait_state", SEL_STATE, 0);
        exp_sig("ifwait_pcw",   SEL_PCW,   0);
        cyc(1'b0, 1'b0);

        // add $3,$1,$2
        fetch_decode("add", 32'h00221820);
        exp_sig("add_exr_state", SEL_STATE, 2);
        exp_sig("add_exr_alu",   SEL_ALU,   4'b0010);
        exp_sig("add_exr_srcb",  SEL_SRCB,  0);
        cyc(1'b1, 1'b0);
        exp_sig("add_wb_state",  SEL_STATE, 3);
        exp_sig("add_wb_regdst", SEL_REGDST, 1);
        exp_sig("add_wb_regw",   SEL_REGW,  1);
        exp_sig("add_wb_m2r",    SEL_M2R,   0);
        cyc(1'b1, 1'b0);

        // lw with three wait cycles in MEM_RD
        fetch_decode("lw", 32'h8C040008);
        exp_sig("lw_ma_state", SEL_STATE, 7);
        exp_sig("lw_ma_srcb",  SEL_SRCB,  2);
        exp_sig("lw_ma_sext",  SEL_SEXT,  1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_sig("lw_rd_state", SEL_STATE, 8);
            exp_sig("lw_rd_mrd",   SEL_MRD,   1);
            exp_sig("lw_rd_iord",  SEL_IORD,  0);
            cyc((i == 3) ? 1'b1 : 1'b0, 1'b0);
        end
        exp_sig("lw_wb_state", SEL_STATE, 9);
        exp_sig("lw_wb_m2r",   SEL_M2R,   1);
        exp_sig("lw_wb_regw",  SEL_REGW,  1);
        cyc(1'b1, 1'b0);

        // beq then bne
        fetch_decode("beq", 32'h10220003);
        exp_sig("beq_state", SEL_STATE, 11);
        exp_sig("beq_pcwc",  SEL_PCWC,  1);
        exp_sig("beq_beq",   SEL_BEQ,   1);
        exp_sig("beq_pcsrc", SEL_PCSRC, 1);
        exp_sig("beq_alu",   SEL_ALU,   4'b0110);
        cyc(1'b1, 1'b0);
        fetch_decode("bne", 32'h14220003);
        exp_sig("bne_state", SEL_STATE, 11);
        exp_sig("bne_beq",   SEL_BEQ,   0);
        exp_sig("bne_pcwc",  SEL_PCWC,  1);
        cyc(1'b1, 1'b0);

        // jal
        fetch_decode("jal", 32'h0C000010);
        exp_sig("jal_state",  SEL_STATE,  13);
        exp_sig("jal_regdst", SEL_REGDST, 2);
        exp_sig("jal_m2r",    SEL_M2R,    3);
        exp_sig("jal_regw",   SEL_REGW,   1);
        exp_sig("jal_pcw",    SEL_PCW,    1);
        exp_sig("jal_pcsrc",  SEL_PCSRC,  2);
        cyc(1'b1, 1'b0);

        // add with overflow suppresses write-back
        fetch_decode("addov", 32'h00221820);
        exp_sig("addov_exr_state", SEL_STATE, 2);
        cyc(1'b1, 1'b1);
        exp_sig("addov_wb_state", SEL_STATE, 3);
        exp_sig("addov_wb_regw",  SEL_REGW,  0);
        cyc(1'b1, 1'b0);

        // lui and ori (zero-extended immediate)
        fetch_decode("lui", 32'h3C01ABCD);
        exp_sig("lui_state", SEL_STATE, 6);
        exp_sig("lui_m2r",   SEL_M2R,   2);
        exp_sig("lui_regw",  SEL_REGW,  1);
        cyc(1'b1, 1'b0);
        fetch_decode("ori", 32'h34210005);
        exp_sig("ori_state", SEL_STATE, 4);
        exp_sig("ori_srcb",  SEL_SRCB,  2);
        exp_sig("ori_sext",  SEL_SEXT,  0);
        exp_sig("ori_alu",   SEL_ALU,   4'b0001);
        cyc(1'b1, 1'b0);
        exp_sig("ori_wb_state", SEL_STATE, 5);
        exp_sig("ori_wb_regw",  SEL_REGW,  1);
        cyc(1'b1, 1'b0);

        // Undefined opcode: illegal pulse in ID, back to IF
        bus.Inst_in = 32'hFC000000;
        exp_sig("ill_if_state", SEL_STATE, 0);
        cyc(1'b1, 1'b0);
        exp_sig("ill_id_state", SEL_STATE, 1);
        exp_sig("ill_id_ill",   SEL_ILL,   1);
        cyc(1'b1, 1'b0);
        exp_sig("ill_next_state", SEL_STATE, 0);
        exp_sig("ill_next_ill",   SEL_ILL,   0);
        cyc(1'b0, 1'b0);

        // Undefined funct: illegal in EX_R
        fetch_decode("badfn", 32'h0000003F);
        exp_sig("badfn_exr_state", SEL_STATE, 2);
        exp_sig("badfn_exr_ill",   SEL_ILL,   1);
        cyc(1'b1, 1'b0);

        // sw, then reset while the write is pending
        fetch_decode("sw", 32'hAC040008);
        exp_sig("sw_ma_state", SEL_STATE, 7);
        cyc(1'b1, 1'b0);
        exp_sig("sw_wr_state", SEL_STATE, 10);
        exp_sig("sw_wr_mwr",   SEL_MWR,   1);
        exp_sig("sw_wr_iord",  SEL_IORD,  0);
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        exp_sig("swrst_mwr",   SEL_MWR,   0);
        exp_sig("swrst_state", SEL_STATE, 0);
        exp_sig("swrst_iord",  SEL_IORD,  1);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;
        fetch_decode("post", 32'h00221820);
        exp_sig("post_exr_state", SEL_STATE, 2);
        cyc(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Multicycle Moore controller for the MIPS multicycle datapath; sits directly upstream of data_path and drives every one of its control inputs.
- Decodes the latched instruction and sequences IF/ID/EX/MEM/WB per instruction class.
- Stalls on MIO_ready for memory/IO accesses.
- Also drives memory strobes and a debug state vector.

Parameters:
- STATE_W, 5, width of state register and state output.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Inst_in  in  32  latched instruction (data_path Inst_R); uses [31:26] opcode, [20:16] rt, [5:0] funct
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- MIO_ready  in  1  memory/IO transfer complete this cycle
- IorD  out  1  1 = PC addresses memory, 0 = ALU_Out
- IRWrite  out  1  load instruction register
- RegDst  out  2  00 rt, 01 rd, 10 $31
- RegWrite  out  1  register file write enable
- MemtoReg  out  2  00 ALU_Out, 01 MDR, 10 {imm,16'h0}, 11 PC
- data2Mem  out  1  store-data select; always 0 (rdata_B)
- ALUSrcA  out  2  00 rs, 01 PC
- ALUSrcB  out  2  00 rt, 01 const 4, 10 imm_ext, 11 imm<<2 sign-extended
- PCSource  out  3  000 res, 001 ALU_Out, 010 jump, 011 res (jr), 100 hold
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  conditional PC write
- Beq  out  1  1 = beq, 0 = bne (when PCWriteCond=1)
- Signext  out  1  1 = sign-extend imm, 0 = zero-extend
- ALU_operation  out  4  ALU op code
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- illegal  out  1  one-cycle pulse on undefined opcode/funct
- state  out  STATE_W  current state (debug)

Behaviour:
- Moore FSM; outputs are combinational from state, plus MIO_ready where noted.
- Default in every state: all strobes 0, PCSource=100, ALU_operation=ADD.
- Reset (async, active-high): state=IF, overflow latch cleared. Outputs during reset equal IF decode.
- IF: IorD=1, MemRead=1, ALUSrcA=01, ALUSrcB=01, ADD, PCSource=000. IRWrite=PCWrite=MIO_ready. Stay in IF while !MIO_ready; otherwise go to ID.
- ID: ALUSrcA=01, ALUSrcB=11, ADD, so the branch target lands in ALU_Out. Next state by opcode:
  - R-type → EX_R; jr (funct 08) → EX_JR
  - lw/sw → MEM_ADDR
  - beq/bne → EX_BR
  - j → EX_J; jal → EX_JAL
  - lui → EX_LUI
  - addi/slti/andi/ori/xori → EX_I
  - anything else → IF with illegal=1
- EX_R: ALUSrcA=00, ALUSrcB=00, op from funct (add, sub, and, or, xor, nor, slt, sll, srl). Undefined funct → IF with illegal=1. Latch overflow for add/sub. → WB_R.
- WB_R: RegDst=01, MemtoReg=00, RegWrite = !ovf_latch. → IF.
- EX_I: ALUSrcB=10. Signext=1 for addi/slti, 0 for logical ops. Latch overflow for addi. → WB_I.
- WB_I: RegDst=00, MemtoReg=00, RegWrite = !ovf_latch. → IF.
- EX_LUI: RegDst=00, MemtoReg=10, RegWrite=1. → IF.
- MEM_ADDR: ALUSrcA=00, ALUSrcB=10, Signext=1, ADD. → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD=0, MemRead=1. Hold until MIO_ready, then → WB_LW.
- WB_LW: RegDst=00, MemtoReg=01, RegWrite=1. → IF.
- MEM_WR: IorD=0, MemWrite=1, data2Mem=0. Hold until MIO_ready, then → IF.
- EX_BR: ALUSrcA=00, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=001, Beq = (opcode==beq). → IF.
- EX_J: PCWrite=1, PCSource=010. → IF.
- EX_JAL: RegDst=10, MemtoReg=11, RegWrite=1, PCWrite=1, PCSource=010. → IF. The $31 write captures the pre-jump PC, already PC+4.
- EX_JR: ALUSrcA=00, ALUSrcB=00, ADD, PCWrite=1, PCSource=011. → IF. Relies on rt=$0.
- ovf_latch: cleared in IF; set in EX states on overflow with an add-type op.
- MIO_ready low forever: FSM holds with strobes stable, no PC or IR update.
- Reset mid-access: FSM returns to IF immediately; strobes drop asynchronously.
- Latencies in cycles, excluding waits: R/I = 4, lui = 3, lw = 5, sw = 4, branch/jump = 3.

Decomposition:
- Package ctrl_defs holds:
  - state encodings
  - opcode and funct constants
  - ALU op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SRL 0101, SUB 0110, SLT 0111, SLL 1000
  - RegDst, MemtoReg, ALUSrc and PCSource select constants
- One sub-module, alu_ctrl: combinational mapping of state-class, opcode and funct to ALU_operation and an illegal flag.

Test Plan:
- Inst_in=0x00221820 (add $3,$1,$2), MIO_ready=1 → states IF,ID,EX_R,WB_R; ALU_operation=0010 in EX_R; RegDst=01, RegWrite=1 in WB_R; 4 cycles.
- Inst_in=0x8C040008 (lw), MIO_ready low 3 cycles in MEM_RD → MemRead held, IorD=0 for 4 cycles; WB_LW MemtoReg=01, RegWrite=1; no state advance while low.
- Inst_in=0x10220003 (beq) → EX_BR with PCWriteCond=1, Beq=1, PCSource=001, ALU_operation=0110. Inst_in=0x14220003 (bne) → Beq=0.
- Inst_in=0x0C000010 (jal) → EX_JAL with RegDst=10, MemtoReg=11, RegWrite=1, PCWrite=1, PCSource=010; then IF.
- add with overflow=1 in EX_R → RegWrite=0 in WB_R. Inst_in=0xFC000000 → illegal pulses one cycle in ID, next state IF.
- Assert reset during MEM_WR → MemWrite drops same cycle, state=IF, IorD=1; after release, normal fetch resumes.
